sm_run_ctrl: RTL and testbench

Run/halt/single-step controller for the schoolMIPS core. Sequences the CPU with a per-cycle enable (`cpu_en`), which gates the PC register update and register-file write in the CPU top. It accepts debug commands over a valid/ready port and stops execution on a single PC breakpoint. It comes out of reset halted, so a program can be loaded before anything executes.

---
 rtl/sm_run_ctrl.sv | 129 ++++++++++++
 tb/tb_sm_run_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_run_ctrl.sv
// Run/halt/single-step controller for the schoolMIPS core.
// Gates CPU execution per cycle, takes debug commands and stops on one PC breakpoint.
module sm_run_ctrl #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [PC_W-1:0]   cmd_arg,
  input  logic [PC_W-1:0]   pc,
  output logic              cpu_en,
  output logic              halted,
  output logic              bp_hit,
  output logic [STEP_W-1:0] step_left,
  output logic [31:0]       instr_count
);

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [2:0] OP_RUN    = 3'd0;
  localparam logic [2:0] OP_HALT   = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_SET_BP = 3'd3;
  localparam logic [2:0] OP_CLR_BP = 3'd4;

  logic [1:0]        state, state_d;
  logic [PC_W-1:0]   bp_addr, bp_addr_d;
  logic              bp_valid, bp_valid_d;
  logic              skip_bp, skip_bp_d;
  logic              bp_hit_d;
  logic [STEP_W-1:0] step_left_d;
  logic [31:0]       instr_count_d;
  logic              bp_match;
  logic              accept;

  // Breakpoint is suppressed until the first instruction after a resume has executed.
  assign bp_match  = bp_valid && (pc == bp_addr) && !skip_bp;
  assign cpu_en    = (state != ST_HALT) && !bp_match;
  assign cmd_ready = (state == ST_HALT) || (cmd_op == OP_HALT);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state;
    bp_addr_d     = bp_addr;
    bp_valid_d    = bp_valid;
    skip_bp_d     = skip_bp;
    bp_hit_d      = bp_hit;
    step_left_d   = step_left;
    instr_count_d = instr_count;

    case (state)
      ST_HALT: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN: begin
              state_d   = ST_RUN;
              bp_hit_d  = 1'b0;
              skip_bp_d = 1'b1;
            end
            OP_STEP: begin
              state_d     = ST_STEP;
              bp_hit_d    = 1'b0;
              skip_bp_d   = 1'b1;
              step_left_d = (cmd_arg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_arg[STEP_W-1:0];
            end
            OP_SET_BP: begin
              bp_addr_d  = cmd_arg;
              bp_valid_d = 1'b1;
            end
            OP_CLR_BP: bp_valid_d = 1'b0;
            default: ;
          endcase
        end
      end
      ST_RUN, ST_STEP: begin
        if (bp_match) begin
          state_d     = ST_HALT;
          bp_hit_d    = 1'b1;
          step_left_d = '0;
        end else begin
          skip_bp_d     = 1'b0;
          instr_count_d = instr_count + 32'd1;
          if (state == ST_STEP) begin
            if (step_left == STEP_W'(1)) begin
              state_d     = ST_HALT;
              step_left_d = '0;
            end else begin
              step_left_d = step_left - STEP_W'(1);
            end
          end
        end
        // Only HALT can be accepted here; it never blocks the current instruction.
        if (accept) begin
          state_d     = ST_HALT;
          step_left_d = '0;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HALT;
      halted      <= 1'b1;
      bp_addr     <= '0;
      bp_valid    <= 1'b0;
      skip_bp     <= 1'b0;
      bp_hit      <= 1'b0;
      step_left   <= '0;
      instr_count <= '0;
    end else begin
      state       <= state_d;
      halted      <= (state_d == ST_HALT);
      bp_addr     <= bp_addr_d;
      bp_valid    <= bp_valid_d;
      skip_bp     <= skip_bp_d;
      bp_hit      <= bp_hit_d;
      step_left   <= step_left_d;
      instr_count <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: directed scenarios plus random commands
// compared every cycle against a behavioural model with a wrapping PC counter.
module tb_sm_run_ctrl;

  localparam logic [31:0] PC_MASK = 32'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic        bp_hit;
  logic [15:0] step_left;
  logic [31:0] instr_count;

  sm_run_ctrl #(.PC_W(32), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .cpu_en(cpu_en),
    .halted(halted), .bp_hit(bp_hit), .step_left(step_left),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int en_seen  = 0;
  logic [31:0] pc_r = 32'd0;

  // Reference model: "stopped" plus a remaining-instruction budget (-1 = unlimited)
  bit          m_stopped;
  int          m_budget;
  bit          m_bp_on;
  logic [31:0] m_bp;
  bit          m_fresh;
  bit          m_hit;
  logic [31:0] m_cnt;
  bit          m_en, m_rdy, m_match;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_stopped = 1'b1; m_budget = 0; m_bp_on = 1'b0; m_bp = 32'd0;
    m_fresh = 1'b0; m_hit = 1'b0; m_cnt = 32'd0;
  endfunction

  function automatic void model_comb(input logic [2:0] op);
    m_match = m_bp_on && (pc_r == m_bp) && !m_fresh;
    m_en    = !m_stopped && !m_match;
    m_rdy   = m_stopped || (op == 3'd1);
  endfunction

  function automatic void model_edge(input bit acc, input logic [2:0] op, input logic [31:0] arg);
    if (m_stopped) begin
      if (acc) begin
        if (op == 3'd0) begin
          m_stopped = 1'b0; m_budget = -1; m_hit = 1'b0; m_fresh = 1'b1;
        end else if (op == 3'd2) begin
          m_stopped = 1'b0; m_hit = 1'b0; m_fresh = 1'b1;
          m_budget = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]);
        end else if (op == 3'd3) begin
          m_bp = arg; m_bp_on = 1'b1;
        end else if (op == 3'd4) begin
          m_bp_on = 1'b0;
        end
      end
    end else begin
      if (m_match) begin
        m_stopped = 1'b1; m_hit = 1'b1; m_budget = 0;
      end else begin
        m_cnt = m_cnt + 32'd1;
        m_fresh = 1'b0;
        if (m_budget > 0) begin
          m_budget--;
          if (m_budget == 0) m_stopped = 1'b1;
        end
      end
      if (acc) begin
        m_stopped = 1'b1; m_budget = 0;
      end
    end
  endfunction

  // One clock: drive, check combinational outputs, clock, check registered outputs.
  task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; pc = pc_r;
    #2;
    model_comb(op);
    check("cpu_en", 32'(cpu_en), 32'(m_en));
    check("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
    if (cpu_en) en_seen++;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(v && m_rdy, op, arg);
      if (m_en) pc_r = (pc_r + 32'd1) & PC_MASK;
    end
    #1;
    check("halted", 32'(halted), 32'(m_stopped));
    check("bp_hit", 32'(bp_hit), 32'(m_hit));
    check("step_left", 32'(step_left), (m_budget > 0) ? 32'(m_budget) : 32'd0);
    check("instr_count", instr_count, m_cnt);
  endtask

  task automatic idle_until_halted(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (halted) break;
      cyc(1'b0, 3'd0, 32'd0);
    end
    check("halt_within_bound", 32'(halted), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 32'd0; pc = 32'd0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;

    // Idle after reset
    en_seen = 0;
    repeat (10) cyc(1'b0, 3'd0, 32'd0);
    check("idle_en", 32'(en_seen), 32'd0);
    check("idle_count", instr_count, 32'd0);

    // STEP 3, then STEP 0
    cyc(1'b1, 3'd2, 32'd3);
    check("step3_load", 32'(step_left), 32'd3);
    en_seen = 0;
    idle_until_halted(20);
    check("step3_en", 32'(en_seen), 32'd3);
    check("step3_count", instr_count, 32'd3);
    cyc(1'b1, 3'd2, 32'd0);
    en_seen = 0;
    idle_until_halted(20);
    check("step0_en", 32'(en_seen), 32'd1);

    // Breakpoint at 5, run from 0, then resume over it
    cyc(1'b1, 3'd3, 32'd5);
    pc_r = 32'd0;
    cyc(1'b1, 3'd0, 32'd0);
    en_seen = 0;
    idle_until_halted(30);
    check("bp_en", 32'(en_seen), 32'd5);
    check("bp_pc", pc_r, 32'd5);
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_count", instr_count, 32'd9);
    cyc(1'b1, 3'd0, 32'd0);
    check("resume_clears_hit", 32'(bp_hit), 32'd0);
    en_seen = 0;
    idle_until_halted(200);
    check("wrap_en", 32'(en_seen), 32'd64);
    check("wrap_pc", pc_r, 32'd5);

    // RUN, stalled SET_BP for 7 cycles, then HALT
    cyc(1'b1, 3'd4, 32'd0);
    cyc(1'b1, 3'd0, 32'd0);
    en_seen = 0;
    repeat (7) cyc(1'b1, 3'd3, 32'd2);
    cyc(1'b1, 3'd1, 32'd0);
    check("halt_en", 32'(en_seen), 32'd8);
    check("halt_halted", 32'(halted), 32'd1);
    cyc(1'b1, 3'd3, 32'd2);

    // HALT coinciding with breakpoint at 2
    pc_r = 32'd0;
    cyc(1'b1, 3'd0, 32'd0);
    cyc(1'b0, 3'd0, 32'd0);
    cyc(1'b0, 3'd0, 32'd0);
    cyc(1'b1, 3'd1, 32'd0);
    check("hbp_pc", pc_r, 32'd2);
    check("hbp_hit", 32'(bp_hit), 32'd1);
    cyc(1'b1, 3'd4, 32'd0);
    cyc(1'b1, 3'd0, 32'd0);
    en_seen = 0;
    repeat (5) cyc(1'b0, 3'd0, 32'd0);
    cyc(1'b1, 3'd1, 32'd0);
    check("clr_en", 32'(en_seen), 32'd6);
    check("clr_pc", pc_r, 32'd8);

    // Reset in the middle of a STEP 20
    cyc(1'b1, 3'd2, 32'd20);
    for (int i = 0; i < 30; i++) begin
      if (step_left == 16'd10) break;
      cyc(1'b0, 3'd0, 32'd0);
    end
    check("mid_step_left", 32'(step_left), 32'd10);
    rst = 1'b1;
    cyc(1'b0, 3'd0, 32'd0);
    rst = 1'b0;
    check("mrst_halted", 32'(halted), 32'd1);
    check("mrst_steps", 32'(step_left), 32'd0);
    check("mrst_count", instr_count, 32'd0);
    check("mrst_cpu_en", 32'(cpu_en), 32'd0);

    // Random commands, PC jumps while stopped, occasional reset
    for (int i = 0; i < 2500; i++) begin
      logic        v;
      logic [2:0]  op;
      logic [31:0] arg;
      v   = ($urandom_range(0, 9) < 3);
      op  = 3'($urandom_range(0, 7));
      arg = (op == 3'd2) ? (($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 7)))
                         : (32'($urandom) & PC_MASK);
      if (halted && $urandom_range(0, 7) == 0) pc_r = 32'($urandom) & PC_MASK;
      rst = ($urandom_range(0, 299) == 0);
      cyc(v, op, arg);
      rst = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
